// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and line constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: bit_end marks the last clk of each serial bit; restart re-aligns to a new frame.
// Single-cycle registered count, no backpressure.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clrn,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;

  assign bit_end = (clk_cnt_q == LAST_CNT);

  always_comb begin
    clk_cnt_d = clk_cnt_q + 1'b1;
    if (restart || bit_end) clk_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) clk_cnt_q <= '0;
    else       clk_cnt_q <= clk_cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead byte FIFO into 8N1 frames (8E1 with UART_TX_PARITY_EN); pop is a Mealy strobe,
// txd/busy registered; frames run back-to-back while fifo_ready stays high, otherwise idles high.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              fifo_ready,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              txd,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .clrn    (clrn),
    .restart (fifo_read),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    // Gated by clrn so a queued byte is never popped while held in reset.
    fifo_read = clrn && fifo_ready && (state_q == IDLE || (state_q == STOP && bit_end));

    case (state_q)
      IDLE: ;
      START: begin
        bit_cnt_d = '0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A pop overrides STOP->IDLE, giving the zero-gap back-to-back frame.
    if (fifo_read) begin
      state_d = START;
      shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_data;
`endif
    end

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, driven from a show-ahead FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_E0 = 11'h7C0, F_55 = 11'h4AA, F_01 = 11'h602, F_FF = 11'h4FE,
                          F_A5 = 11'h54A, F_AA = 11'h554, F_E1 = 11'h5C2, F_E2 = 11'h5C4,
                          F_E3 = 11'h7C6;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_E0 = 11'h3C0, F_55 = 11'h2AA, F_01 = 11'h202, F_FF = 11'h3FE,
                          F_A5 = 11'h34A, F_AA = 11'h354, F_E1 = 11'h3C2, F_E2 = 11'h3C4,
                          F_E3 = 11'h3C6;
`endif
  localparam int FL = NB * CPB;

  typedef struct {
    logic [7:0]  din;
    logic [10:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       fifo_ready = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read, txd, busy;

  int         vecs = 0;
  int         fails = 0;
  int         pops = 0;
  int         exp_pops = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .fifo_ready (fifo_ready),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .txd        (txd),
    .busy       (busy)
  );

  task automatic refresh();
    fifo_ready = (q.size() != 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    exp_pops++;
    refresh();
  endtask

  // FIFO model: the pop takes effect at the edge where fifo_read is high.
  always @(posedge clk) begin
    if (fifo_read === 1'b1) begin
      #1;
      if (q.size() != 0) void'(q.pop_front());
      pops++;
      refresh();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic run_frame(input logic [10:0] bits, input logic last_read);
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      chk("frame_txd", {31'd0, txd}, {31'd0, bits[c / CPB]});
      chk("frame_busy", {31'd0, busy}, 32'd1);
      chk("frame_read", {31'd0, fifo_read}, (c == FL - 1) ? {31'd0, last_read} : 32'd0);
    end
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_txd", {31'd0, txd}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_read", {31'd0, fifo_read}, 32'd0);
    chk("pop_count", pops, exp_pops);
  endtask

  task automatic wait_start();
    int n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_found", {31'd0, (n < 20)}, 32'd1);
  endtask

  initial begin
    vec_t       tbl[5];
    logic [7:0] exp6[5];
    logic       par6[5];
    logic [10:0] rx;

    tbl[0] = '{8'he0, F_E0};
    tbl[1] = '{8'h55, F_55};
    tbl[2] = '{8'h01, F_01};
    tbl[3] = '{8'hff, F_FF};
    tbl[4] = '{8'ha5, F_A5};
    exp6 = '{8'he0, 8'he1, 8'he2, 8'he3, 8'he4};
    par6 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values, then 50 idle cycles with the FIFO empty.
    #2 clrn = 1'b0;
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_read", {31'd0, fifo_read}, 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 50; i++) idle_chk();

    // Single-byte frames from the table.
    for (int v = 0; v < 5; v++) begin
      push(tbl[v].din);
      #1 chk("tbl_pop_req", {31'd0, fifo_read}, 32'd1);
      run_frame(tbl[v].frame, 1'b0);
      idle_chk();
    end

    // Three preloaded bytes: pops in each last stop cycle, no idle gap.
    push(8'he1); push(8'he2); push(8'he3);
    #1 chk("b2b_pop_req", {31'd0, fifo_read}, 32'd1);
    run_frame(F_E1, 1'b1);
    run_frame(F_E2, 1'b1);
    run_frame(F_E3, 1'b0);
    idle_chk();

    // Reset in the middle of the data bits of 8'h55.
    push(8'h55); push(8'haa);
    #1 chk("rst_pop_req", {31'd0, fifo_read}, 32'd1);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("pre_rst_txd", {31'd0, txd}, {31'd0, F_55[c / CPB]});
    end
    #1 clrn = 1'b0;
    #1;
    chk("mid_rst_txd", {31'd0, txd}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_read", {31'd0, fifo_read}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_read", {31'd0, fifo_read}, 32'd0);
      chk("in_rst_pops", pops, exp_pops - 1);
    end
    clrn = 1'b1;
    #1 chk("post_rst_pop_req", {31'd0, fifo_read}, 32'd1);
    run_frame(F_AA, 1'b0);
    idle_chk();

    // FIFO empty during a frame, then refilled mid-frame.
    push(8'h01);
    #1 chk("late_pop_req", {31'd0, fifo_read}, 32'd1);
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      chk("late_txd", {31'd0, txd}, {31'd0, F_01[c / CPB]});
      chk("late_read", {31'd0, fifo_read}, (c == FL - 1) ? 32'd1 : 32'd0);
      if (c == 20) push(8'ha5);
    end
    run_frame(F_A5, 1'b0);
    idle_chk();

    // Five queued bytes decoded off the serial line.
    for (int i = 0; i < 5; i++) push(exp6[i]);
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      wait_start();
      rx = '0;
      repeat (2) @(negedge clk);
      rx[0] = txd;
      for (int k = 1; k < NB; k++) begin
        repeat (4) @(negedge clk);
        rx[k] = txd;
      end
      chk("rx_start", {31'd0, rx[0]}, 32'd0);
      chk("rx_data", {24'd0, rx[8:1]}, {24'd0, exp6[f]});
      chk("rx_stop", {31'd0, rx[NB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
      chk("rx_parity", {31'd0, rx[9]}, {31'd0, par6[f]});
`endif
      repeat (2) @(negedge clk);
    end
    chk("fifo_empty", q.size(), 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_pops", pops, exp_pops);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Serial transmitter that drains the byte FIFO directly downstream of it. It pops one byte whenever the FIFO reports ready and shifts it out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, then stop bit. Frames run back-to-back with no idle gap while the FIFO stays non-empty. It connects to the FIFO's read, data_out and ready pins with no glue logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
DATA_W, 8, data bits per frame; must match the FIFO width.

Ports:
clk  input  1  system clock; all state changes on the rising edge
clrn  input  1  asynchronous active-low reset
fifo_ready  input  1  FIFO non-empty; fifo_data is valid while this is high
fifo_data  input  DATA_W  FIFO head word (FIFO data_out)
fifo_read  output  1  pop strobe to the FIFO read pin; the pop happens at the edge where it is high
txd  output  1  serial line; idle high
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, txd=1, busy=0, fifo_read=0.
  - Bit and clock counters and the shift register clear.
  - Reset mid-frame aborts the frame immediately. txd returns high with no stop bit.
  - No FIFO pop is issued during reset.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit_cnt counts 0..DATA_W-1.
  - bit_end = (clk_cnt == CLKS_PER_BIT-1).
- fifo_read is Mealy and combinational: fifo_ready && (state==IDLE || (state==STOP && bit_end)).
  - It is high for exactly one cycle per byte.
  - It is never asserted while fifo_ready=0.
- At an edge with fifo_read=1:
  - shift register <= fifo_data, taken in the same cycle as the pop.
  - state <= START, clk_cnt <= 0.
- txd is registered:
  - START drives 0.
  - DATA drives shift[0]; the register shifts right at each bit_end.
  - PARITY drives the parity bit.
  - STOP drives 1.
  - IDLE drives 1.
- Transitions, each taken at bit_end:
  - START -> DATA.
  - DATA -> DATA while bit_cnt < DATA_W-1, otherwise -> PARITY (or -> STOP without the macro).
  - PARITY -> STOP.
  - STOP -> START if fifo_ready, otherwise -> IDLE.
- Latency:
  - Pop in IDLE at edge N; txd falls at edge N, so the start bit occupies cycles N..N+CLKS_PER_BIT-1.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity.
- Back-to-back frames: the pop happens in the last stop cycle, so the next start bit follows the stop bit with zero idle cycles.
- Boundary cases:
  - FIFO empties mid-frame: the current frame completes, then the block returns to IDLE.
  - fifo_ready rising during a frame: ignored until the stop bit_end.
  - FIFO overflow is not visible to this block and is not handled here.
- busy = (state != IDLE). It is registered with state.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists, the parity bit is even parity (^shift data latched at pop), and the frame is DATA_W+3 bits.
- Undefined: no PARITY state, no parity logic, and DATA goes straight to STOP.

Decomposition:
- Package fifo_uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam IDLE_LEVEL = 1'b1.
- One sub-module, uart_baud_cnt:
  - Owns clk_cnt and generates bit_end.
  - Inputs are clk, clrn and restart (asserted on pop).

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Reset release with FIFO empty (fifo_ready=0) -> txd=1, busy=0, fifo_read=0 for 50 cycles.
2. One byte 8'he0, fifo_ready=1 for one pop -> fifo_read high for exactly 1 cycle.
   - txd holds each of 0 | 0,0,0,0,0,1,1,1 | 1 for 4 cycles: 40 cycles total.
   - The same byte with UART_TX_PARITY_EN: parity bit=1, 44 cycles total.
3. FIFO preloaded with 8'he1,8'he2,8'he3 -> three pops 40 cycles apart, each in the last stop cycle; no idle-high gap; busy stays high for 120 cycles, then drops.
4. clrn pulsed low in the middle of the DATA bits of 8'h55 -> txd=1 and busy=0 asynchronously.
   - No extra pop occurs.
   - After release with fifo_ready=1, a fresh frame of the next byte starts.
5. fifo_ready held low during a frame, then raised mid-frame -> no fifo_read before the stop bit's last cycle.
6. Wired to the real FIFO with writes of 8'he0..8'he4 -> decoded serial bytes equal the write order exactly, and the FIFO ends empty.
